// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between the CPU core and the
// debug/loader port: one transaction at a time, fixed wait states, one-cycle ack per transaction.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int WAIT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT                 stateReg, stateNext;
    // Owner of the current (or most recent) transaction; doubles as last_grant.
    logic                  grantDbgReg, grantDbgNext;
    logic                  loadTxn;
    logic                  captureRead;
    logic                  weReg;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [DATA_WIDTH-1:0] wdataReg;
    logic [WAIT_WIDTH-1:0] waitCntReg;
    logic [1:0]            capturePort;
    logic [DATA_WIDTH-1:0] portRdata [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            grantDbgReg <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            grantDbgReg <= grantDbgNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        grantDbgNext = grantDbgReg;
        loadTxn      = 1'b0;
        captureRead  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On a tie the port that did not win last time gets the bus.
                    grantDbgNext = dbg_req && (!cpu_req || !grantDbgReg);
                    loadTxn      = 1'b1;
                    stateNext    = ACCESS;
                end
            end
            ACCESS: begin
                if (waitCntReg == '0) begin
                    captureRead = !weReg;
                    stateNext   = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weReg      <= 1'b0;
            addrReg    <= '0;
            wdataReg   <= '0;
            waitCntReg <= '0;
        end else if (loadTxn) begin
            weReg      <= grantDbgNext ? dbg_we    : cpu_we;
            addrReg    <= grantDbgNext ? dbg_addr  : cpu_addr;
            wdataReg   <= grantDbgNext ? dbg_wdata : cpu_wdata;
            waitCntReg <= WAIT_WIDTH'(WAIT_CYCLES);
        end else if (stateReg == ACCESS && waitCntReg != '0) begin
            waitCntReg <= waitCntReg - 1'b1;
        end
    end

    // Port 0 is the CPU, port 1 the debug port; each keeps its own read-data register.
    assign capturePort = {captureRead & grantDbgReg, captureRead & ~grantDbgReg};

    for (genvar gi = 0; gi < 2; gi++) begin : gPort
        logic [DATA_WIDTH-1:0] rdataReg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdataReg <= '0;
            end else if (capturePort[gi]) begin
                rdataReg <= mem_rdata;
            end
        end

        assign portRdata[gi] = rdataReg;
    end

    assign cpu_rdata = portRdata[0];
    assign dbg_rdata = portRdata[1];

    assign busy      = (stateReg != IDLE);
    assign mem_we    = (stateReg == ACCESS) && weReg;
    assign mem_oe    = (stateReg == ACCESS) && !weReg;
    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign cpu_ack   = (stateReg == DONE) && !grantDbgReg;
    assign dbg_ack   = (stateReg == DONE) && grantDbgReg;
    assign cpu_stall = cpu_req && !cpu_ack;

endmodule
